microsequencer: RTL and testbench

Steps the microcode ROM for the control decoder. Holds the T-state counter and builds the ROM address from the current opcode and T-state. Presents the gated microinstruction word to the decoder. Latches ALU flags and resolves microcode jump conditions into a PC-load strobe. Sits between the instruction register, the microcode ROM and the control decoder, and handles memory/device wait stalls and halt at instruction boundaries.

---
 rtl/microsequencer.sv | 138 +++++++++++++
 tb/tb_microsequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Microcode sequencer: owns the T-state counter, forms the microcode ROM
// address from {opcode, tstate}, gates the ROM word to the control decoder,
// latches ALU flags on EO steps and resolves conditional jumps into a
// PC-load strobe. Handles wait stalls and halting at instruction boundaries.
module microsequencer #(
  parameter int OPW = 8,
  parameter int TW  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPW-1:0]     opcode,
  output logic [OPW+TW-1:0]  rom_addr,
  input  logic [15:0]        rom_data,
  output logic [15:0]        uinstr,
  input  logic               alu_c,
  input  logic               alu_z,
  input  logic               alu_n,
  input  logic               wait_req,
  input  logic               halt_req,
  output logic               jump_taken,
  output logic [TW-1:0]      tstate,
  output logic               halted,
  output logic               ustep_overflow
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [TW-1:0]   r_tstate;
  logic            r_flag_c;
  logic            r_flag_z;
  logic            r_flag_n;
  logic            r_ovf;

  logic            w_exec;
  logic            w_halted;
  logic            w_eo;
  logic            w_rt;
  logic            w_tmax;
  logic            w_jc;
  logic            w_jz;
  logic            w_jgt;
  logic            w_jlt;

  // Microword field decode; RT is only meaningful on non-EO words.
  assign w_eo   = rom_data[15];
  assign w_rt   = rom_data[11] & ~rom_data[15];
  assign w_jc   = rom_data[5];
  assign w_jz   = rom_data[4];
  assign w_jgt  = rom_data[3];
  assign w_jlt  = rom_data[2];
  assign w_tmax = &r_tstate;

  // State register; reset lands in BOOT so the first cycle is a NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the execute/halted qualifiers for this cycle.
  always_comb begin
    w_state_next = r_state;
    w_exec       = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_next = S_RUN;
      end
      S_RUN: begin
        // A pending wait blocks both the step and any halt it would trigger.
        w_exec = ~wait_req;
        if (~wait_req && w_rt && halt_req) begin
          w_state_next = S_HALT;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (!halt_req) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_BOOT;
      end
    endcase
  end

  // T-state counter, latched ALU flags and sticky overflow error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tstate <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_HALT) begin
      r_tstate <= '0;
    end else if (w_exec) begin
      if (w_eo) begin
        r_flag_c <= alu_c;
        r_flag_z <= alu_z;
        r_flag_n <= alu_n;
      end
      if (w_rt) begin
        r_tstate <= '0;
      end else if (w_tmax) begin
        // Ran off the end of the step space: wrap like an RT, but flag it
        // and never honour a halt request here.
        r_tstate <= '0;
        r_ovf    <= 1'b1;
      end else begin
        r_tstate <= r_tstate + 1'b1;
      end
    end
  end

  // Combinational outputs; jumps test only the latched flags.
  always_comb begin
    rom_addr       = {opcode, r_tstate};
    uinstr         = w_exec ? rom_data : 16'h0000;
    jump_taken     = w_exec & ((w_jc  & r_flag_c) |
                               (w_jz  & r_flag_z) |
                               (w_jgt & ~r_flag_z & ~r_flag_n) |
                               (w_jlt & r_flag_n));
    tstate         = r_tstate;
    halted         = w_halted;
    ustep_overflow = r_ovf;
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a small microcode ROM model feeds the
// DUT combinationally, each cycle's inputs are driven 2 time units after the
// rising edge and outputs are checked 1 unit later.
module tb_microsequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  opcode;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] uinstr;
  logic        alu_c;
  logic        alu_z;
  logic        alu_n;
  logic        wait_req;
  logic        halt_req;
  logic        jump_taken;
  logic [2:0]  tstate;
  logic        halted;
  logic        ustep_overflow;

  logic [15:0] rom_mem [0:2047];
  int          total;
  int          bad;

  microsequencer #(.OPW(8), .TW(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .uinstr         (uinstr),
    .alu_c          (alu_c),
    .alu_z          (alu_z),
    .alu_n          (alu_n),
    .wait_req       (wait_req),
    .halt_req       (halt_req),
    .jump_taken     (jump_taken),
    .tstate         (tstate),
    .halted         (halted),
    .ustep_overflow (ustep_overflow)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic w, input logic h, input logic c, input logic z, input logic n);
    wait_req = w;
    halt_req = h;
    alu_c    = c;
    alu_z    = z;
    alu_n    = n;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 16'h0000;
    // op 12: plain 4-step instruction, RT at T3
    rom_mem[{8'h12, 3'd0}] = 16'h0001;
    rom_mem[{8'h12, 3'd1}] = 16'h0002;
    rom_mem[{8'h12, 3'd2}] = 16'h0003;
    rom_mem[{8'h12, 3'd3}] = 16'h0800;
    // op 20: EO then JZ
    rom_mem[{8'h20, 3'd0}] = 16'h8000;
    rom_mem[{8'h20, 3'd1}] = 16'h0010;
    rom_mem[{8'h20, 3'd2}] = 16'h0800;
    // op 21: EO then JLT
    rom_mem[{8'h21, 3'd0}] = 16'h8000;
    rom_mem[{8'h21, 3'd1}] = 16'h0004;
    rom_mem[{8'h21, 3'd2}] = 16'h0800;
    // op 22: EO with z=0, JZ against live z=1, then RT+JGT
    rom_mem[{8'h22, 3'd0}] = 16'h8000;
    rom_mem[{8'h22, 3'd1}] = 16'h0010;
    rom_mem[{8'h22, 3'd2}] = 16'h0808;
    // op 30: stall target, JZ at T2
    rom_mem[{8'h30, 3'd0}] = 16'h8000;
    rom_mem[{8'h30, 3'd1}] = 16'h0001;
    rom_mem[{8'h30, 3'd2}] = 16'h0010;
    rom_mem[{8'h30, 3'd3}] = 16'h0800;
    // op 40: halt test, 4 steps
    rom_mem[{8'h40, 3'd0}] = 16'h0101;
    rom_mem[{8'h40, 3'd1}] = 16'h0001;
    rom_mem[{8'h40, 3'd2}] = 16'h0001;
    rom_mem[{8'h40, 3'd3}] = 16'h0800;
    // op 50: never returns
    for (int t = 0; t < 8; t++) rom_mem[{8'h50, 3'(t)}] = 16'h0001;

    reset  = 1'b1;
    opcode = 8'h12;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_tstate", 32'(tstate), 0);
    check_eq("rst_uinstr", 32'(uinstr), 0);
    check_eq("rst_jump", 32'(jump_taken), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_ovf", 32'(ustep_overflow), 0);

    // Reset release: one BOOT NOP, then T0 of op 12
    reset = 1'b0;
    #1;
    check_eq("boot_uinstr", 32'(uinstr), 0);
    check_eq("boot_tstate", 32'(tstate), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("c1_rom_addr", 32'(rom_addr), 'h090);
    check_eq("c1_tstate", 32'(tstate), 0);
    check_eq("c1_uinstr", 32'(uinstr), 'h0001);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("c2_tstate", 32'(tstate), 1);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("c3_tstate", 32'(tstate), 2);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("c4_tstate", 32'(tstate), 3);
    check_eq("c4_uinstr_rt", 32'(uinstr), 'h0800);

    // JZ after EO with z=1
    next_cycle(); opcode = 8'h20; drive(0, 0, 0, 1, 0);
    check_eq("rt_wrap_tstate", 32'(tstate), 0);
    check_eq("rt_ovf", 32'(ustep_overflow), 0);
    check_eq("eo_uinstr", 32'(uinstr), 'h8000);
    check_eq("eo_jump", 32'(jump_taken), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("jz_taken", 32'(jump_taken), 1);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("op20_t2", 32'(tstate), 2);

    // JLT after EO with z=1, n=0
    next_cycle(); opcode = 8'h21; drive(0, 0, 0, 1, 0);
    check_eq("op21_t0", 32'(tstate), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("jlt_not_taken", 32'(jump_taken), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);

    // JZ must ignore live alu_z when latched z is 0
    next_cycle(); opcode = 8'h22; drive(0, 0, 0, 0, 0);
    check_eq("op22_t0", 32'(tstate), 0);
    next_cycle(); drive(0, 0, 0, 1, 0);
    check_eq("jz_live_ignored", 32'(jump_taken), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("jgt_taken", 32'(jump_taken), 1);

    // Stall at T2 for 4 cycles (latched z=1, T2 word carries JZ)
    next_cycle(); opcode = 8'h30; drive(0, 0, 0, 1, 0);
    check_eq("op30_t0", 32'(tstate), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("op30_t1", 32'(tstate), 1);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); drive(1, 0, 0, 0, 0);
      check_eq($sformatf("stall%0d_tstate", k), 32'(tstate), 2);
      check_eq($sformatf("stall%0d_uinstr", k), 32'(uinstr), 0);
      check_eq($sformatf("stall%0d_jump", k), 32'(jump_taken), 0);
    end
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("unstall_tstate", 32'(tstate), 2);
    check_eq("unstall_uinstr", 32'(uinstr), 'h0010);
    check_eq("unstall_jump", 32'(jump_taken), 1);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("op30_t3", 32'(tstate), 3);

    // Halt requested at T1; wait at the RT step holds it off one cycle
    next_cycle(); opcode = 8'h40; drive(0, 0, 0, 0, 0);
    check_eq("op40_t0_uinstr", 32'(uinstr), 'h0101);
    next_cycle(); drive(0, 1, 0, 0, 0);
    check_eq("op40_t1", 32'(tstate), 1);
    next_cycle(); drive(0, 1, 0, 0, 0);
    next_cycle(); drive(1, 1, 0, 0, 0);
    check_eq("waithalt_uinstr", 32'(uinstr), 0);
    next_cycle(); drive(0, 1, 0, 0, 0);
    check_eq("waithalt_halted", 32'(halted), 0);
    check_eq("waithalt_tstate", 32'(tstate), 3);
    check_eq("rt_halt_uinstr", 32'(uinstr), 'h0800);
    next_cycle(); drive(0, 1, 0, 0, 0);
    check_eq("halt_halted", 32'(halted), 1);
    check_eq("halt_uinstr", 32'(uinstr), 0);
    check_eq("halt_tstate", 32'(tstate), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("halt_hold", 32'(halted), 1);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("resume_halted", 32'(halted), 0);
    check_eq("resume_tstate", 32'(tstate), 0);
    check_eq("resume_uinstr", 32'(uinstr), 'h0101);
    repeat (3) begin
      next_cycle(); drive(0, 0, 0, 0, 0);
    end

    // Overflow: 8 steps without RT
    for (int t = 0; t < 8; t++) begin
      next_cycle(); opcode = 8'h50; drive(0, 1, 0, 0, 0);
      check_eq($sformatf("ovf_step%0d", t), 32'(tstate), 32'(t));
      check_eq($sformatf("ovf_flag%0d", t), 32'(ustep_overflow), 0);
    end
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("ovf_wrap_tstate", 32'(tstate), 0);
    check_eq("ovf_set", 32'(ustep_overflow), 1);
    check_eq("ovf_no_halt", 32'(halted), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("ovf_sticky", 32'(ustep_overflow), 1);
    check_eq("ovf_next_t1", 32'(tstate), 1);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_tstate", 32'(tstate), 0);
    check_eq("areset_ovf", 32'(ustep_overflow), 0);
    check_eq("areset_uinstr", 32'(uinstr), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("areset_boot_uinstr", 32'(uinstr), 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    check_eq("areset_t0_uinstr", 32'(uinstr), 'h0001);
    check_eq("areset_t0_tstate", 32'(tstate), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
